circuit: RTL and testbench



---
 rtl/circuit_delay_line.sv | 27 ++
 rtl/circuit.sv | 32 +++
 tb/tb_circuit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/circuit_delay_line.sv
// rtl/circuit_delay_line.sv - enable-gated N-stage sample history with synchronous clear
module circuit_delay_line #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // h[0] is the newest accepted sample, h[N-1] the one about to drop out
  logic [W-1:0] h [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) h[i] <= '0;
    end else if (en) begin
      h[0] <= din;
      for (int i = 1; i < N; i++) h[i] <= h[i-1];
    end
  end

  assign dout = h[N-1];

endmodule

// File: rtl/circuit.sv
// rtl/circuit.sv - moving-window accumulator over the last N accepted samples
module circuit #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] oldest;

  circuit_delay_line #(.W(W), .N(N)) u_delay_line (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (x),
    .dout (oldest)
  );

  // modulo-2^W running sum stays bit-exact with the direct N-term sum
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (en) begin
      y <= y + x - oldest;
    end
  end

endmodule

// File: tb/tb_circuit.sv
// tb/tb_circuit.sv - scoreboard bench for circuit with N=4 and N=1 instances
module tb_circuit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] x;
  logic [31:0] y4;
  logic [31:0] y1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] y4;
    logic [31:0] y1;
    string       name;
  } exp_t;

  exp_t q[$];

  logic [31:0] m4 [4];
  logic [31:0] m1;
  logic        stim_done = 1'b0;

  always #5 clk = ~clk;

  circuit #(.W(32), .N(4)) dut4 (.clk(clk), .rst(rst), .en(en), .x(x), .y(y4));
  circuit #(.W(32), .N(1)) dut1 (.clk(clk), .rst(rst), .en(en), .x(x), .y(y1));

  // monitor: y is valid after every edge, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (y4 !== e.y4) begin
          errors++;
          $display("FAIL %s n4: got %h expected %h", e.name, y4, e.y4);
        end
        checks++;
        if (y1 !== e.y1) begin
          errors++;
          $display("FAIL %s n1: got %h expected %h", e.name, y1, e.y1);
        end
      end
    end
  end

  // one edge; hand value used for N=4 when has_exp, otherwise the direct-sum model
  task automatic step(input logic r, input logic e, input logic [31:0] xv,
                      input logic [31:0] exp4, input bit has_exp, input string name);
    exp_t ent;
    rst = r;
    en  = e;
    x   = xv;
    if (r) begin
      for (int i = 0; i < 4; i++) m4[i] = '0;
      m1 = '0;
    end else if (e) begin
      for (int i = 3; i > 0; i--) m4[i] = m4[i-1];
      m4[0] = xv;
      m1 = xv;
    end
    ent.y4   = has_exp ? exp4 : (m4[0] + m4[1] + m4[2] + m4[3]);
    ent.y1   = m1;
    ent.name = name;
    @(posedge clk);
    q.push_back(ent);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 4; i++) m4[i] = '0;
    m1  = '0;
    rst = 1'b1;
    en  = 1'bx;
    x   = 'x;
    @(negedge clk);

    step(1'b1, 1'b1, 32'h1234_5678, 32'd0, 1'b1, "reset");
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, "reset");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom, 32'd0, 1'b1, "reset_hold");

    step(1'b0, 1'b1, 32'd1, 32'd1,  1'b1, "fill1");
    step(1'b0, 1'b1, 32'd2, 32'd3,  1'b1, "fill2");
    step(1'b0, 1'b1, 32'd3, 32'd6,  1'b1, "fill3");
    step(1'b0, 1'b1, 32'd4, 32'd10, 1'b1, "fill4");
    step(1'b0, 1'b1, 32'd5, 32'd14, 1'b1, "slide5");
    step(1'b0, 1'b1, 32'd6, 32'd18, 1'b1, "slide6");

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd100, 32'd18, 1'b1, "hold");
    step(1'b0, 1'b1, 32'd7, 32'd22, 1'b1, "after_hold");

    step(1'b1, 1'b1, 32'd9, 32'd0, 1'b1, "mid_reset");
    step(1'b0, 1'b1, 32'd7, 32'd7, 1'b1, "post_reset");

    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, "wrap_reset");
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "wrap1");
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "wrap2");

    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, "rand_reset");
    for (int i = 0; i < 100; i++)
      step(1'b0, 1'($urandom_range(1)), $urandom, 32'd0, 1'b0, "random");

    stim_done = 1'b1;
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
